// File: rtl/mio_pkg.sv
// Shared constants and types for the MIO bus responder.
// Region map, FSM states and one-hot region hit bundle.
package mio_pkg;

  localparam logic [31:0] RAM_LIMIT = 32'h0000_FFFF;
  localparam logic [31:0] LED_ADDR  = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic ram;
    logic led;
    logic sw;
    logic cnt;
    logic none;
  } hit_t;

endpackage

// File: rtl/mio_addr_decode.sv
// Address decoder: maps a byte address to a one-hot region hit.
// Byte offset bits are masked so only word addresses are compared.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [31:0] addr_bus,
  output hit_t        hit
);

  logic [31:0] word;

  assign word = addr_bus & ~32'h3;

  always_comb begin
    hit = '0;
    unique case (1'b1)
      (word <= RAM_LIMIT): hit.ram  = 1'b1;
      (word == LED_ADDR):  hit.led  = 1'b1;
      (word == SW_ADDR):   hit.sw   = 1'b1;
      (word == CNT_ADDR):  hit.cnt  = 1'b1;
      default:             hit.none = 1'b1;
    endcase
  end

endmodule

// File: rtl/mio_bus_responder.sv
// CPU memory/IO responder: RAM, LED, switch and free-running counter.
// Single FSM with registered completion pulse and read data.
module mio_bus_responder
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] addr_bus,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  state_t      state;
  hit_t        hit;
  logic [31:0] cnt;
  logic [31:0] rd_mux;
  logic        accept;

  mio_addr_decode u_dec (
    .addr_bus (addr_bus),
    .hit      (hit)
  );

  assign accept   = (state == IDLE) && CPU_MIO;
  assign ram_addr = addr_bus[11:2];
  assign ram_din  = Data_out;
  assign ram_we   = accept && mem_w && hit.ram && !rst;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit.led: rd_mux = {16'h0, led_out};
      hit.sw:  rd_mux = {16'h0, sw_in};
      hit.cnt: rd_mux = cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      MIO_ready <= 1'b0;
      Data_in   <= '0;
      led_out   <= '0;
      cnt       <= '0;
    end else begin
      // a CNT write below overrides this increment
      cnt       <= cnt + 32'd1;
      MIO_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CPU_MIO) begin
            if (mem_w) begin
              state     <= RESP;
              MIO_ready <= 1'b1;
              if (hit.led) led_out <= Data_out[15:0];
              if (hit.cnt) cnt <= Data_out;
            end else if (hit.ram) begin
              state <= RAM_WAIT;
            end else begin
              state     <= RESP;
              MIO_ready <= 1'b1;
              Data_in   <= rd_mux;
            end
          end
        end
        RAM_WAIT: begin
          state     <= RESP;
          MIO_ready <= 1'b1;
          Data_in   <= ram_dout;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder with a completion scoreboard.
// Expected read data and completion cycle are queued at issue time.
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [15:0] sw_in;
  logic [15:0] led_out;

  mio_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .CPU_MIO   (CPU_MIO),
    .mem_w     (mem_w),
    .addr_bus  (addr_bus),
    .Data_out  (Data_out),
    .Data_in   (Data_in),
    .MIO_ready (MIO_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  int          step   = 0;
  logic [31:0] last_rd = '0;
  logic [15:0] led_m   = '0;
  logic [31:0] cbase   = '0;
  int          ccyc    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (MIO_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", {31'b0, MIO_ready}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("step%0d_ready_cyc", mon_e.id),
            cyc, mon_e.cyc);
        chk($sformatf("step%0d_data_in", mon_e.id),
            Data_in, mon_e.data);
      end
    end
  end

  task automatic txn(input logic        w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [31:0] rd_exp,
                     input int          lat,
                     input int          gap,
                     input bit          cnt_rd);
    exp_t e;
    bit   seen;
    bit   is_ram;
    CPU_MIO = 1'b0;
    repeat (gap + 1) @(negedge clk);
    CPU_MIO  = 1'b1;
    mem_w    = w;
    addr_bus = a;
    Data_out = d;
    step++;
    is_ram = (a <= 32'h0000_FFFF);
    if (!w) last_rd = cnt_rd ? cbase + 32'(cyc - ccyc) : rd_exp;
    if (w && a == 32'hE000_0000) led_m = d[15:0];
    if (w && a == 32'hF000_0004) begin
      cbase = d;
      ccyc  = cyc + 1;
    end
    e.data = last_rd;
    e.cyc  = cyc + lat;
    e.id   = step;
    sb.push_back(e);
    #1;
    chk($sformatf("step%0d_ram_we_accept", step),
        {31'b0, ram_we}, {31'b0, w && is_ram});
    if (w && is_ram) begin
      chk($sformatf("step%0d_ram_addr", step),
          {22'b0, ram_addr}, {22'b0, a[11:2]});
      chk($sformatf("step%0d_ram_din", step), ram_din, d);
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = MIO_ready;
    end
    chk($sformatf("step%0d_ready_seen", step),
        {31'b0, seen}, 32'd1);
    chk($sformatf("step%0d_ram_we_resp", step),
        {31'b0, ram_we}, 32'd0);
    chk($sformatf("step%0d_led", step),
        {16'b0, led_out}, {16'b0, led_m});
    CPU_MIO = 1'b0;
  endtask

  initial begin
    int k;
    int pulses;
    rst      = 1'b1;
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    addr_bus = 32'h10;
    Data_out = 32'h55;
    sw_in    = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ready", {31'b0, MIO_ready}, 32'd0);
    chk("rst_data_in", Data_in, 32'd0);
    chk("rst_led", {16'b0, led_out}, 32'd0);
    rst     = 1'b0;
    CPU_MIO = 1'b0;

    txn(1, 32'h10, 32'hDEAD_BEEF, 0, 1, 0, 0);
    txn(0, 32'h10, 0, 32'hDEAD_BEEF, 2, 0, 0);
    txn(1, 32'hFFFC, 32'hCAFE_F00D, 0, 1, 1, 0);
    txn(0, 32'hFFFC, 0, 32'hCAFE_F00D, 2, 0, 0);
    txn(0, 32'h10, 0, 32'hDEAD_BEEF, 2, 2, 0);
    txn(0, 32'h0001_0000, 0, 32'h0, 1, 0, 0);

    txn(1, 32'hE000_0000, 32'h1234_A5A5, 0, 1, 0, 0);
    txn(0, 32'hE000_0000, 0, 32'h0000_A5A5, 1, 1, 0);
    sw_in = 16'h00FF;
    txn(0, 32'hF000_0000, 0, 32'h0000_00FF, 1, 0, 0);
    txn(1, 32'hF000_0000, 32'hFFFF_FFFF, 0, 1, 0, 0);
    txn(0, 32'hF000_0000, 0, 32'h0000_00FF, 1, 0, 0);

    txn(1, 32'hF000_0004, 32'hFFFF_FFFE, 0, 1, 0, 0);
    txn(0, 32'hF000_0004, 0, 0, 1, 1, 1);
    txn(1, 32'hF000_0004, 32'h1234_5678, 0, 1, 3, 0);
    txn(0, 32'hF000_0004, 0, 0, 1, 0, 1);

    txn(0, 32'h8000_0000, 0, 32'h0, 1, 0, 0);
    txn(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0, 0);
    txn(0, 32'hE000_0000, 0, 32'h0000_A5A5, 1, 0, 0);

    // held request: two back-to-back reads of the switches
    sw_in = 16'h3C3C;
    @(negedge clk);
    CPU_MIO  = 1'b1;
    mem_w    = 1'b0;
    addr_bus = 32'hF000_0000;
    k        = cyc;
    step++;
    last_rd  = 32'h0000_3C3C;
    sb.push_back('{last_rd, k + 1, step});
    sb.push_back('{last_rd, k + 3, step});
    pulses = 0;
    for (int i = 0; i < 10 && pulses < 2; i++) begin
      @(negedge clk);
      if (MIO_ready) pulses++;
    end
    CPU_MIO = 1'b0;
    chk("held_pulses", pulses, 2);
    repeat (3) @(negedge clk);

    // reset while a RAM read is in RAM_WAIT
    CPU_MIO  = 1'b1;
    mem_w    = 1'b0;
    addr_bus = 32'h10;
    @(negedge clk);
    rst     = 1'b1;
    CPU_MIO = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {31'b0, MIO_ready}, 32'd0);
    chk("midrst_data_in", Data_in, 32'd0);
    chk("midrst_led", {16'b0, led_out}, 32'd0);
    last_rd = '0;
    led_m   = '0;
    repeat (2) @(negedge clk);
    chk("midrst_no_ready", {31'b0, MIO_ready}, 32'd0);
    txn(0, 32'h10, 0, 32'hDEAD_BEEF, 2, 0, 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
